// File: rtl/scanline_sequencer.sv
// rtl/scanline_sequencer.sv - row-window sweep sequencer feeding parallel colour-fill lanes
//
// Sweeps the inclusive row window [i_row_first, min(i_row_last, MAX_ROW)].
// It hands each row to the lowest-numbered idle fill lane through a go/done
// handshake. On abort it stops issuing rows and waits for outstanding lanes.
//
// Ports:
//   i_clk         system clock
//   i_n_rst       asynchronous active-low reset
//   i_start       one-cycle sweep request, honoured only while idle
//   i_abort       level; suppresses issue and drains outstanding lanes
//   i_row_first   first row of the window, latched on accepted start
//   i_row_last    last row (inclusive), clamped to MAX_ROW, latched on start
//   o_lane_go     one-cycle issue pulse per lane
//   o_lane_row    row per lane, lane i at [i*ROW_W +: ROW_W], held until re-issue
//   i_lane_done   one-cycle completion pulse per lane
//   o_busy        high in every state except idle
//   o_done        one-cycle end-of-sweep pulse
//   o_aborted     valid with o_done; sweep ended by abort
//   o_rows_done   saturating count of rows completed in the current/last sweep

module scanline_sequencer #(
    parameter int ROW_W     = 16,
    parameter int NUM_LANES = 2,
    parameter int MAX_ROW   = 479
) (
    input  logic                         i_clk,
    input  logic                         i_n_rst,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [ROW_W-1:0]             i_row_first,
    input  logic [ROW_W-1:0]             i_row_last,
    output logic [NUM_LANES-1:0]         o_lane_go,
    output logic [NUM_LANES*ROW_W-1:0]   o_lane_row,
    input  logic [NUM_LANES-1:0]         i_lane_done,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_aborted,
    output logic [ROW_W-1:0]             o_rows_done
);

    localparam logic [ROW_W-1:0]     LP_MAX_ROW = ROW_W'(MAX_ROW);
    localparam int                   LP_CNT_W   = $clog2(NUM_LANES + 1);
    localparam logic [NUM_LANES-1:0] LP_ONE     = NUM_LANES'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                         r_state;
    logic [ROW_W-1:0]               r_next_row;
    logic [ROW_W-1:0]               r_last_row;
    logic [NUM_LANES-1:0]           r_lane_busy;
    logic [NUM_LANES*ROW_W-1:0]     r_lane_row;
    logic                           r_aborted;
    logic [ROW_W-1:0]               r_rows_done;

    logic [NUM_LANES-1:0]           w_free;
    logic [NUM_LANES-1:0]           w_sel;
    logic                           w_have_free;
    logic                           w_issue;
    logic [NUM_LANES-1:0]           w_accept;
    logic [LP_CNT_W-1:0]            w_done_cnt;
    logic [ROW_W:0]                 w_rows_sum;
    logic [ROW_W-1:0]               w_rows_next;
    logic [ROW_W-1:0]               w_last_clamped;

    // Lowest-index idle lane as a one-hot: x & -x isolates the lowest set bit.
    assign w_free      = ~r_lane_busy;
    assign w_sel       = w_free & ((~w_free) + LP_ONE);
    assign w_have_free = |w_free;

    // The issue decision is combinational on registered state. That allows a
    // lane freed at one edge to take its next row in the following cycle.
    // It also lets abort veto an issue in the same cycle it is raised.
    assign w_issue   = (r_state == S_ISSUE) && !i_abort && w_have_free;
    assign o_lane_go = w_issue ? w_sel : '0;

    // Completions only count for lanes that actually hold a row.
    assign w_accept = i_lane_done & r_lane_busy;

    always_comb begin
        w_done_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_done_cnt = w_done_cnt + LP_CNT_W'(w_accept[i]);
        end
    end

    assign w_rows_sum  = {1'b0, r_rows_done} + (ROW_W + 1)'(w_done_cnt);
    assign w_rows_next = w_rows_sum[ROW_W] ? '1 : w_rows_sum[ROW_W-1:0];

    assign w_last_clamped = (i_row_last > LP_MAX_ROW) ? LP_MAX_ROW : i_row_last;

    // The lane being issued sees its new row in the same cycle as its go pulse.
    // The registered copy then holds that row until the lane is issued again.
    always_comb begin
        o_lane_row = r_lane_row;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (o_lane_go[i]) begin
                o_lane_row[i*ROW_W +: ROW_W] = r_next_row;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_state     <= S_IDLE;
            r_next_row  <= '0;
            r_last_row  <= '0;
            r_lane_busy <= '0;
            r_lane_row  <= '0;
            r_aborted   <= 1'b0;
            r_rows_done <= '0;
        end else begin
            r_lane_busy <= (r_lane_busy & ~w_accept) | o_lane_go;
            r_rows_done <= w_rows_next;

            for (int i = 0; i < NUM_LANES; i++) begin
                if (o_lane_go[i]) begin
                    r_lane_row[i*ROW_W +: ROW_W] <= r_next_row;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_next_row  <= i_row_first;
                        r_last_row  <= w_last_clamped;
                        r_rows_done <= '0;
                        r_aborted   <= 1'b0;
                        // An empty window finishes without issuing anything.
                        r_state     <= (i_row_first > w_last_clamped) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DRAIN;
                    end else if (w_have_free) begin
                        r_next_row <= r_next_row + ROW_W'(1);
                        if (r_next_row == r_last_row) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Uses the busy flags as they stand this cycle. A lane that
                    // completes now is seen as idle only on the next check.
                    if (r_lane_busy == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_aborted   = r_aborted;
    assign o_rows_done = r_rows_done;

endmodule

// File: tb/tb_scanline_sequencer.sv
// tb/tb_scanline_sequencer.sv - directed bench for scanline_sequencer with behavioural fill lanes

module tb_scanline_sequencer;

    localparam int W  = 16;
    localparam int NL = 2;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            start;
    logic            abort;
    logic [W-1:0]    row_first;
    logic [W-1:0]    row_last;
    logic [NL-1:0]   lane_go;
    logic [NL*W-1:0] lane_row;
    logic [NL-1:0]   lane_done;
    logic            busy;
    logic            done;
    logic            aborted;
    logic [W-1:0]    rows_done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int            lat [NL];
    int            cnt [NL];
    logic [NL-1:0] mbusy;
    logic [NL-1:0] spur;
    logic [NL-1:0] w_d;
    int            go_lane [$];
    int            go_row  [$];
    int            busy_viol;
    int            done_cnt;
    int            done_cyc;
    int            done_rows;
    logic          done_ab;

    int s_cyc;
    int base_go;
    int base_done;
    int ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scanline_sequencer #(.ROW_W(W), .NUM_LANES(NL), .MAX_ROW(479)) dut (
        .i_clk       (clk),
        .i_n_rst     (n_rst),
        .i_start     (start),
        .i_abort     (abort),
        .i_row_first (row_first),
        .i_row_last  (row_last),
        .o_lane_go   (lane_go),
        .o_lane_row  (lane_row),
        .i_lane_done (lane_done),
        .o_busy      (busy),
        .o_done      (done),
        .o_aborted   (aborted),
        .o_rows_done (rows_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_sweep(input int first, input int last);
        row_first = W'(first);
        row_last  = W'(last);
        start     = 1'b1;
        s_cyc     = cyc;
        base_go   = go_lane.size();
        base_done = done_cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == base_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("done_once", 32'(done_cnt - base_done), 32'd1);
    endtask

    // Fill-lane model: a go seen in cycle t produces a done pulse in cycle t+lat.
    initial begin
        lane_done = '0;
        mbusy     = '0;
        busy_viol = 0;
        done_cnt  = 0;
        done_cyc  = 0;
        done_rows = 0;
        done_ab   = 1'b0;
        for (int i = 0; i < NL; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!n_rst) begin
                for (int i = 0; i < NL; i++) cnt[i] = 0;
                mbusy     = '0;
                lane_done = spur;
            end else begin
                w_d = '0;
                for (int i = 0; i < NL; i++) begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            w_d[i]   = 1'b1;
                            mbusy[i] = 1'b0;
                        end
                    end
                end
                lane_done = w_d | spur;
                for (int i = 0; i < NL; i++) begin
                    if (lane_go[i]) begin
                        if (mbusy[i]) busy_viol++;
                        go_lane.push_back(i);
                        go_row.push_back(int'(lane_row[i*W +: W]));
                        cnt[i]   = lat[i];
                        mbusy[i] = 1'b1;
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc  = cyc;
                    done_rows = int'(rows_done);
                    done_ab   = aborted;
                end
            end
        end
    end

    initial begin
        n_rst     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        row_first = '0;
        row_last  = '0;
        spur      = '0;
        lat[0]    = 1;
        lat[1]    = 1;

        repeat (3) @(negedge clk);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_lane_go",   32'(lane_go),   32'd0);
        check("rst_lane_row",  32'(lane_row),  32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_aborted",   32'(aborted),   32'd0);
        check("rst_rows_done", 32'(rows_done), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Full frame, single-cycle lanes: rows 0..479 in order.
        start_sweep(0, 479);
        wait_done(3000);
        check("full_go_count", 32'(go_lane.size() - base_go), 32'd480);
        ok = 1;
        for (int j = 0; j < 480; j++) begin
            if (base_go + j >= go_row.size() || go_row[base_go + j] != j) ok = 0;
        end
        check("full_row_order", 32'(ok), 32'd1);
        check("full_rows_done", 32'(done_rows), 32'd480);
        check("full_aborted",   32'(done_ab),   32'd0);

        // One row on lane 0 with a single-cycle lane: 2*1+2 cycles start to done.
        start_sweep(55, 55);
        wait_done(50);
        check("one_latency",   32'(done_cyc - s_cyc), 32'd4);
        check("one_lane_row",  32'(go_lane[base_go] * 1000 + go_row[base_go]), 32'd55);
        check("one_rows_done", 32'(done_rows), 32'd1);

        // Empty window: done one cycle after start, nothing issued.
        start_sweep(20, 5);
        wait_done(50);
        check("empty_latency",   32'(done_cyc - s_cyc), 32'd1);
        check("empty_go_count",  32'(go_lane.size() - base_go), 32'd0);
        check("empty_rows_done", 32'(done_rows), 32'd0);

        // Rows 10..13 over two lanes with 3-cycle lanes.
        lat[0] = 3;
        lat[1] = 3;
        start_sweep(10, 13);
        wait_done(100);
        check("two_go_count", 32'(go_lane.size() - base_go), 32'd4);
        check("two_issue0", 32'(go_lane[base_go]     * 1000 + go_row[base_go]),     32'd10);
        check("two_issue1", 32'(go_lane[base_go + 1] * 1000 + go_row[base_go + 1]), 32'd1011);
        check("two_issue2", 32'(go_lane[base_go + 2] * 1000 + go_row[base_go + 2]), 32'd12);
        check("two_issue3", 32'(go_lane[base_go + 3] * 1000 + go_row[base_go + 3]), 32'd1013);
        check("two_rows_done", 32'(done_rows), 32'd4);
        check("two_latency",   32'(done_cyc - s_cyc), 32'd11);

        // row_last beyond MAX_ROW is clamped to 479.
        lat[0] = 1;
        lat[1] = 1;
        start_sweep(478, 600);
        wait_done(100);
        check("clamp_go_count", 32'(go_lane.size() - base_go), 32'd2);
        check("clamp_row0",     32'(go_row[base_go]),     32'd478);
        check("clamp_row1",     32'(go_row[base_go + 1]), 32'd479);
        check("clamp_rows_done", 32'(done_rows), 32'd2);

        // Abort after three issues with both lanes still holding rows.
        lat[0] = 2;
        lat[1] = 6;
        start_sweep(100, 199);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (go_lane.size() - base_go >= 3) break;
        end
        abort = 1'b1;
        wait_done(100);
        abort = 1'b0;
        check("abort_go_count",  32'(go_lane.size() - base_go), 32'd3);
        check("abort_latency",   32'(done_cyc - s_cyc), 32'd10);
        check("abort_flag",      32'(done_ab),   32'd1);
        check("abort_rows_done", 32'(done_rows), 32'd3);
        check("abort_held",      32'(aborted),   32'd1);

        // Spurious done on an idle lane plus a second start while busy.
        lat[0] = 3;
        lat[1] = 3;
        start_sweep(30, 33);
        row_first = W'(200);
        start     = 1'b1;
        spur      = 2'b10;
        @(negedge clk);
        start = 1'b0;
        spur  = '0;
        wait_done(100);
        check("spur_go_count",  32'(go_lane.size() - base_go), 32'd4);
        check("spur_first_row", 32'(go_row[base_go]),     32'd30);
        check("spur_last_row",  32'(go_row[base_go + 3]), 32'd33);
        check("spur_rows_done", 32'(done_rows), 32'd4);
        check("spur_latency",   32'(done_cyc - s_cyc), 32'd11);
        check("spur_aborted",   32'(done_ab),   32'd0);
        check("no_busy_issue",  32'(busy_viol), 32'd0);

        // Reset in the middle of a sweep.
        lat[0] = 1;
        lat[1] = 1;
        start_sweep(0, 479);
        repeat (5) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_lane_go",   32'(lane_go),   32'd0);
        check("midrst_rows_done", 32'(rows_done), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        start_sweep(7, 7);
        wait_done(50);
        check("recover_go_count",  32'(go_lane.size() - base_go), 32'd1);
        check("recover_row",       32'(go_row[go_row.size() - 1]), 32'd7);
        check("recover_rows_done", 32'(done_rows), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
